// File: rtl/spi_slave_cmd_parser.sv
// SPI slave command parser, sclk domain.
// Decodes the command / address / payload words coming out of the receive
// shifter, reprograms the shifter's next word length, and issues write, read
// and config-register-write requests toward the bus-side CDC FIFOs.
//
// Ports:
//   sclk, rstn          SPI clock (rising edge) / async active-low reset (~cs & sys_rstn)
//   rx_data[31:0]       completed shifter word, valid with rx_data_ready
//   rx_data_ready       last bit of the current word is on the line this cycle
//   rx_counter[7:0]     next word length minus 1 (combinational)
//   rx_counter_upd      load rx_counter into the shifter (combinational)
//   dummy_cycles[7:0]   read turnaround length in bits, 0 = none
//   wr_valid/wr_ready   write request pulse / write FIFO not full
//   wr_addr, wr_data    write request payload, held until the next write
//   rd_req, rd_addr     read request pulse and address
//   reg_wr_valid/_data  config register write pulse and value
//   wr_overflow         sticky: a write word was dropped on a full FIFO
//   cmd_err             sticky: unknown opcode received
module spi_slave_cmd_parser #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [7:0]  CMD_WRITE  = 8'h02,
    parameter logic [7:0]  CMD_READ   = 8'h0B,
    parameter logic [7:0]  CMD_WRREG  = 8'h11
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic [31:0]           rx_data,
    input  logic                  rx_data_ready,
    output logic [7:0]            rx_counter,
    output logic                  rx_counter_upd,
    input  logic [7:0]            dummy_cycles,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  reg_wr_valid,
    output logic [7:0]            reg_wr_data,
    output logic                  wr_overflow,
    output logic                  cmd_err
);

    localparam logic [7:0] LEN_WORD = 8'd31;
    localparam logic [7:0] LEN_BYTE = 8'd7;

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_DUMMY   = 3'd3,
        ST_REGDATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  reg_wr_valid_q, reg_wr_valid_d;
    logic [7:0]            reg_wr_data_q, reg_wr_data_d;
    logic                  wr_overflow_q, wr_overflow_d;
    logic                  cmd_err_q, cmd_err_d;

    logic [7:0]            cmd;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic                  cmd_is_mem;

    assign cmd        = rx_data[7:0];
    assign rx_addr    = rx_data[ADDR_WIDTH-1:0];
    assign cmd_is_mem = (cmd == CMD_WRITE) || (cmd == CMD_READ);

    // State register
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a completed word advances the parser
    always_comb begin
        state_d = state_q;
        if (rx_data_ready) begin
            unique case (state_q)
                ST_CMD: begin
                    if (cmd_is_mem)              state_d = ST_ADDR;
                    else if (cmd == CMD_WRREG)   state_d = ST_REGDATA;
                    else                         state_d = ST_DONE;
                end
                ST_ADDR: begin
                    if (!is_read_q)              state_d = ST_WDATA;
                    else if (dummy_cycles != '0) state_d = ST_DUMMY;
                    else                         state_d = ST_DONE;
                end
                ST_DUMMY:   state_d = ST_DONE;
                ST_REGDATA: state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic; shifter reload is combinational, requests are registered next cycle
    always_comb begin
        rx_counter     = '0;
        rx_counter_upd = 1'b0;
        is_read_d      = is_read_q;
        addr_d         = addr_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        rd_req_d       = 1'b0;
        rd_addr_d      = rd_addr_q;
        reg_wr_valid_d = 1'b0;
        reg_wr_data_d  = reg_wr_data_q;
        wr_overflow_d  = wr_overflow_q;
        cmd_err_d      = cmd_err_q;
        if (rx_data_ready) begin
            unique case (state_q)
                ST_CMD: begin
                    is_read_d = (cmd == CMD_READ);
                    if (cmd_is_mem) begin
                        rx_counter_upd = 1'b1;
                        rx_counter     = LEN_WORD;
                    end else if (cmd == CMD_WRREG) begin
                        rx_counter_upd = 1'b1;
                        rx_counter     = LEN_BYTE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                ST_ADDR: begin
                    addr_d = rx_addr;
                    if (!is_read_q) begin
                        rx_counter_upd = 1'b1;
                        rx_counter     = LEN_WORD;
                    end else if (dummy_cycles != '0) begin
                        rx_counter_upd = 1'b1;
                        rx_counter     = dummy_cycles - 8'd1;
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = rx_addr;
                    end
                end
                ST_DUMMY: begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q;
                end
                ST_WDATA: begin
                    // Address advances even for dropped words so the burst stays aligned
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    if (wr_ready) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_data;
                    end else begin
                        wr_overflow_d = 1'b1;
                    end
                end
                ST_REGDATA: begin
                    reg_wr_valid_d = 1'b1;
                    reg_wr_data_d  = rx_data[7:0];
                end
                default: ;
            endcase
        end
    end

    // Datapath and request registers; reset also kills any pulse in flight
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            is_read_q      <= 1'b0;
            addr_q         <= '0;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            reg_wr_valid_q <= 1'b0;
            reg_wr_data_q  <= '0;
            wr_overflow_q  <= 1'b0;
            cmd_err_q      <= 1'b0;
        end else begin
            is_read_q      <= is_read_d;
            addr_q         <= addr_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            reg_wr_valid_q <= reg_wr_valid_d;
            reg_wr_data_q  <= reg_wr_data_d;
            wr_overflow_q  <= wr_overflow_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_req       = rd_req_q;
    assign rd_addr      = rd_addr_q;
    assign reg_wr_valid = reg_wr_valid_q;
    assign reg_wr_data  = reg_wr_data_q;
    assign wr_overflow  = wr_overflow_q;
    assign cmd_err      = cmd_err_q;

endmodule
